// File: rtl/frogger_lane_engine.sv
// frogger_lane_engine: scrolling obstacle lanes, player tracking, collision
// detection, lives/score game FSM and a one-cycle pixel query port.
module frogger_lane_engine #(
  parameter int COLS          = 20,
  parameter int LANES         = 13,
  parameter int SPD_W         = 3,
  parameter int LIVES         = 3,
  parameter int SCORE_W       = 4,
  parameter int RESPAWN_TICKS = 4,
  localparam int CW   = $clog2(COLS),
  localparam int RW   = $clog2(LANES + 2),
  localparam int LV_W = $clog2(LIVES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               tick,
  input  logic               cfg_we,
  input  logic [RW-1:0]      cfg_lane,
  input  logic [COLS-1:0]    cfg_pattern,
  input  logic               cfg_dir,
  input  logic [SPD_W-1:0]   cfg_div,
  input  logic               mv_up,
  input  logic               mv_down,
  input  logic               mv_left,
  input  logic               mv_right,
  input  logic [CW-1:0]      pix_col,
  input  logic [RW-1:0]      pix_row,
  output logic               pix_obs,
  output logic               pix_player,
  output logic [CW-1:0]      player_col,
  output logic [RW-1:0]      player_row,
  output logic               hit,
  output logic [LV_W-1:0]    lives,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state
);

  localparam int RC_W = $clog2(RESPAWN_TICKS + 1);
  localparam logic [CW-1:0] HOME_COL = CW'(COLS / 2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_PLAY    = 2'b01,
    S_RESPAWN = 2'b10,
    S_OVER    = 2'b11
  } state_t;

  state_t cur_state, nxt_state;

  logic [COLS-1:0]  lane_pat [1:LANES];
  logic             lane_dir [1:LANES];
  logic [SPD_W-1:0] lane_div [1:LANES];
  logic [SPD_W-1:0] lane_cnt [1:LANES];

  logic [RC_W-1:0] resp_cnt;
  logic            resp_last;
  logic            overlap;
  logic            scroll_en;
  logic            move_en;
  logic            collide;
  logic            goal_move;
  logic [CW-1:0]   nxt_col;
  logic [RW-1:0]   nxt_row;

  // Obstacle bit at (row, col); rows outside the lane range and columns past
  // the playfield read as empty so safe rows and blanking never collide.
  function automatic logic lane_bit(input logic [RW-1:0] row, input logic [CW-1:0] col);
    logic b;
    b = 1'b0;
    for (int i = 1; i <= LANES; i++) begin
      if (row == RW'(i) && int'(col) < COLS) b = lane_pat[i][col];
    end
    return b;
  endfunction

  assign overlap   = lane_bit(player_row, player_col);
  assign resp_last = (resp_cnt == RC_W'(RESPAWN_TICKS - 1));
  assign state     = cur_state;

  // Game state register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state elements use non-blocking assignment so every register
    // samples pre-edge values regardless of process ordering.
    if (reset) cur_state <= S_IDLE;
    else       cur_state <= nxt_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves nxt_state unassigned (no latch).
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:    if (start) nxt_state = S_PLAY;
      S_PLAY:    if (overlap) nxt_state = (lives == LV_W'(1)) ? S_OVER : S_RESPAWN;
      S_RESPAWN: if (tick && resp_last) nxt_state = S_PLAY;
      S_OVER:    if (!start) nxt_state = S_IDLE;
      default:   nxt_state = S_IDLE;
    endcase
  end

  // FSM outputs: when lanes scroll, when moves count, when a collision fires.
  always_comb begin
    scroll_en = 1'b0;
    move_en   = 1'b0;
    collide   = 1'b0;
    case (cur_state)
      S_PLAY: begin
        scroll_en = 1'b1;
        collide   = overlap;
        move_en   = !overlap;
      end
      S_RESPAWN: scroll_en = 1'b1;
      default: ;
    endcase
  end

  // Move arbitration: opposite pairs cancel, then up > down > left > right,
  // clamped at the field edges; an up move out of the last lane scores.
  always_comb begin
    logic up_e, dn_e, lf_e, rt_e;
    up_e      = mv_up & ~mv_down;
    dn_e      = mv_down & ~mv_up;
    lf_e      = mv_left & ~mv_right;
    rt_e      = mv_right & ~mv_left;
    nxt_col   = player_col;
    nxt_row   = player_row;
    goal_move = 1'b0;
    if (up_e) begin
      if (player_row == RW'(LANES)) goal_move = 1'b1;
      else                          nxt_row = player_row + RW'(1);
    end else if (dn_e) begin
      if (player_row != '0) nxt_row = player_row - RW'(1);
    end else if (lf_e) begin
      if (player_col != '0) nxt_col = player_col - CW'(1);
    end else if (rt_e) begin
      if (player_col != CW'(COLS - 1)) nxt_col = player_col + CW'(1);
    end
  end

  // Lane bitmaps: a configuration write overrides that lane's rotation.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the lane store is reset explicitly because its contents are
    // visible through pix_obs and collisions straight out of reset.
    if (reset) begin
      for (int i = 1; i <= LANES; i++) begin
        lane_pat[i] <= '0;
        lane_dir[i] <= 1'b0;
        lane_div[i] <= '0;
        lane_cnt[i] <= '0;
      end
    end else begin
      for (int i = 1; i <= LANES; i++) begin
        if (cfg_we && cfg_lane == RW'(i)) begin
          lane_pat[i] <= cfg_pattern;
          lane_dir[i] <= cfg_dir;
          lane_div[i] <= cfg_div;
          lane_cnt[i] <= '0;
        end else if (scroll_en && tick) begin
          if (lane_cnt[i] == lane_div[i]) begin
            lane_cnt[i] <= '0;
            if (lane_dir[i]) lane_pat[i] <= {lane_pat[i][COLS-2:0], lane_pat[i][COLS-1]};
            else             lane_pat[i] <= {lane_pat[i][0], lane_pat[i][COLS-1:1]};
          end else begin
            lane_cnt[i] <= lane_cnt[i] + SPD_W'(1);
          end
        end
      end
    end
  end

  // Player position, lives, score, respawn timer and hit pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      player_col <= HOME_COL;
      player_row <= '0;
      lives      <= '0;
      score      <= '0;
      resp_cnt   <= '0;
      hit        <= 1'b0;
    end else begin
      hit <= collide;
      case (cur_state)
        S_IDLE: if (start) begin
          lives      <= LV_W'(LIVES);
          score      <= '0;
          player_col <= HOME_COL;
          player_row <= '0;
        end
        S_PLAY: begin
          if (collide) begin
            lives    <= lives - LV_W'(1);
            resp_cnt <= '0;
          end else if (move_en) begin
            if (goal_move) begin
              if (score != '1) score <= score + SCORE_W'(1);
              player_col <= HOME_COL;
              player_row <= '0;
            end else begin
              player_col <= nxt_col;
              player_row <= nxt_row;
            end
          end
        end
        S_RESPAWN: if (tick) begin
          if (resp_last) begin
            player_col <= HOME_COL;
            player_row <= '0;
          end else begin
            resp_cnt <= resp_cnt + RC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered pixel query for the VGA pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_obs    <= 1'b0;
      pix_player <= 1'b0;
    end else begin
      pix_obs    <= lane_bit(pix_row, pix_col);
      pix_player <= (pix_col == player_col) && (pix_row == player_row) && (cur_state != S_OVER);
    end
  end

endmodule

// File: doc/frogger_lane_engine.md
# frogger_lane_engine

Parametrised playfield engine for the lane-crossing VGA game: holds LANES scrolling obstacle lanes of COLS cells, each with its own direction and speed, and tracks a player cell that moves on button pulses with edge clamping. It detects collisions, keeps lives and score in a small game FSM, and answers per-pixel cell queries from the VGA pixel pipeline with one cycle of latency. It sits between the clock divider/button logic and the RGB output register of the VGA top level.

## Interface
- COLS, 20: cells per lane; CW = $clog2(COLS).
- LANES, 13: obstacle lanes, rows 1..LANES; row 0 = start (safe), row LANES+1 = goal (safe); RW = $clog2(LANES+2).
- SPD_W, 3: width of per-lane speed divider.
- LIVES, 3: lives at game start; LV_W = $clog2(LIVES+1).
- SCORE_W, 4: score width.
- RESPAWN_TICKS, 4: tick strobes spent in RESPAWN.
- clk  in  1  system clock; all state on posedge clk.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; starts a game / acknowledges game over.
- tick  in  1  one-cycle scroll strobe (base scroll rate).
- cfg_we  in  1  lane configuration write strobe.
- cfg_lane  in  RW  lane index written; only 1..LANES accepted.
- cfg_pattern  in  COLS  obstacle bitmap (bit c = column c).
- cfg_dir  in  1  1 = rotate toward MSB, 0 = toward LSB.
- cfg_div  in  SPD_W  lane rotates once per (cfg_div+1) ticks.
- mv_up, mv_down, mv_left, mv_right  in  1 each  one-cycle move pulses.
- pix_col  in  CW  queried column; pix_row  in  RW  queried row.
- pix_obs  out  1  registered: queried cell holds an obstacle.
- pix_player  out  1  registered: queried cell holds the player.
- player_col  out  CW; player_row  out  RW  player position.
- hit  out  1  one-cycle collision pulse.
- lives  out  LV_W; score  out  SCORE_W.
- state  out  2  IDLE=00, PLAY=01, RESPAWN=10, OVER=11.

## Operation
- Reset: all lanes 0, dir 0, div 0, divider counters 0, state IDLE, lives 0, score 0, player (COLS/2, 0), hit/pix_obs/pix_player 0.
- IDLE: lanes frozen, moves ignored; start=1 -> PLAY, lives<=LIVES, score<=0, player<=(COLS/2,0).
- PLAY: lanes scroll, moves accepted. Overlap = row in 1..LANES and lane[row][col]=1. On an overlap edge: hit<=1, lives<=lives-1, that cycle's move ignored; lives was 1 -> OVER, else RESPAWN.
- RESPAWN: lanes scroll, moves ignored; after RESPAWN_TICKS ticks -> PLAY with player at (COLS/2,0).
- OVER: lanes frozen; start=0 -> IDLE. lives/score hold.
- Moves: at most one per cycle. Opposite pair both set -> both of that pair ignored; remaining priority up > down > left > right. Clamp: no move below row 0, left of col 0, right of COLS-1 (no wrap).
- Up move into row LANES+1: score+1 (saturate at 2^SCORE_W-1), player returns to (COLS/2,0) on the same edge; no overlap check on goal row.
- Scroll: per lane, on tick cnt==div -> rotate one cell, cnt<=0; else cnt+1. dir=1: bit c -> c+1, bit COLS-1 -> 0; dir=0 mirrored.
- cfg write: loads pattern/dir/div, clears cnt; wins over same-edge rotation of that lane. Invalid cfg_lane ignored. Accepted in every state.
- Pixel query: pix_obs <= pix_row in 1..LANES and pix_col<COLS and lane bit; pix_player <= position match and state != OVER.

## Timing
- pix_obs/pix_player: 1 cycle after pix_col/pix_row.
- Move pulse at edge N -> player_* updated after edge N.
- Overlap present before edge N -> hit high cycle N+1 only, lives/state updated at edge N.
- Overlap created by a rotation or move at edge N is seen at edge N+1.
- Reset mid-game: immediate return to reset values, independent of clk.

## Test plan
- Reset, start=1, COLS=20: state PLAY, lives 3, score 0, player (10,0); pix query (10,0) -> pix_player=1 next cycle.
- Lane 1 = 0x00001, dir 1, div 2; 6 ticks in PLAY -> lane 1 = 0x00004; dir 0 from 0x00001, 1 tick at div 0 -> 0x80000.
- Lane 1 bit 10 set, div 7, mv_up -> hit pulse 1 cycle, lives 2, RESPAWN; after 4 ticks PLAY, player (10,0).
- Three collisions -> OVER, lives 0; start held -> stays OVER; start=0 -> IDLE.
- All lanes 0, 14 mv_up pulses -> score 1, player (10,0); mv_left at col 0 -> stays 0; mv_left+mv_right same cycle -> no move.
- cfg_we to lane 3 on a rotating tick -> written pattern unrotated; cfg_lane 0 and 14 -> no change; reset asserted mid-PLAY -> all outputs reset values without a clk edge.
